// File: rtl/wave_pkg.sv
// Shared types and constants for the rectangular-wave sequencing controller.
package wave_pkg;

  localparam int ACC_W_DEF = 16;
  localparam int CNT_W_DEF = 8;
  localparam logic [7:0] DUTY_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  // One complete configuration set (active or pending).
  typedef struct packed {
    logic [ACC_W_DEF-1:0] inc;
    logic [7:0]           duty;
    logic [3:0]           step;
    logic [CNT_W_DEF-1:0] cycles;
  } cfg_t;

  // Duty sweep: add in 9 bits so the carry is visible, then clamp at full scale.
  function automatic logic [7:0] duty_sat_add(input logic [7:0] duty,
                                              input logic [3:0] step);
    logic [8:0] sum;
    sum = {1'b0, duty} + {5'b0, step};
    return sum[8] ? DUTY_MAX : sum[7:0];
  endfunction

endpackage

// File: rtl/wave_ctrl_phase_acc.sv
// Phase accumulator: adds inc every enabled cycle, reports the carry as wrap.
module phase_acc #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] inc,
  output logic [ACC_W-1:0] acc,
  output logic             wrap
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;

  assign sum  = {1'b0, acc_q} + {1'b0, inc};
  // The carry is dropped from the stored value, so acc wraps modulo 2^ACC_W.
  assign wrap = en & sum[ACC_W];
  assign acc  = acc_q;

  // Next accumulator value; clear has priority over accumulation.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path can infer a latch.
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = sum[ACC_W-1:0];
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/wave_ctrl.sv
// Sequencing controller: config handshake, run/burst FSM and duty sweep.
module wave_ctrl
  import wave_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic [7:0]       cfg_duty,
  input  logic [3:0]       cfg_step,
  input  logic [CNT_W-1:0] cfg_cycles,
  input  logic             start,
  input  logic             stop,
  output logic [7:0]       phase,
  output logic [7:0]       duty_cycle,
  output logic             out_en,
  output logic             period_tick,
  output logic             done,
  output logic             busy
);

  state_t           state_q, state_d;
  cfg_t             act_q, act_d, pend_q, pend_d, cfg_in;
  logic             pend_full_q, pend_full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d, done_q, done_d, ready_q, ready_d;
  logic             acc_clr, acc_en, wrap, accept, burst_end;
  logic [ACC_W-1:0] acc;

  assign cfg_in    = '{inc: cfg_inc, duty: cfg_duty, step: cfg_step, cycles: cfg_cycles};
  assign accept    = cfg_valid & ready_q;
  assign acc_en    = (state_q != IDLE);
  assign burst_end = (act_q.cycles != '0) && ((cnt_q + CNT_W'(1)) == act_q.cycles);

  phase_acc #(.ACC_W(ACC_W)) u_phase_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (acc_clr),
    .en   (acc_en),
    .inc  (act_q.inc),
    .acc  (acc),
    .wrap (wrap)
  );

  // Next-state, config bookkeeping and pulse generation.
  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    cnt_d       = cnt_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;
    acc_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        // A config that landed in pending on the exiting wrap is promoted here.
        if (pend_full_q) begin
          act_d       = pend_q;
          pend_full_d = 1'b0;
        end
        if (accept) act_d = cfg_in;
        if (start && !stop && act_q.inc != '0) state_d = RUN;
      end
      RUN, STOPPING: begin
        if (wrap) begin
          tick_d     = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          act_d.duty = duty_sat_add(act_q.duty, act_q.step);
          // Pending is checked from its registered flag, so a config accepted
          // on this very wrap waits for the following one.
          if (pend_full_q) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
          end
          if (state_q == STOPPING || burst_end) begin
            state_d = IDLE;
            done_d  = (state_q == RUN);
            acc_clr = 1'b1;
            cnt_d   = '0;
          end else if (stop) begin
            state_d = STOPPING;
          end
        end else if (state_q == RUN && stop) begin
          state_d = STOPPING;
        end
        if (accept) begin
          pend_d      = cfg_in;
          pend_full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) | ~pend_full_d;
  end

  // Controller state, configuration sets and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      act_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign phase       = acc[ACC_W-1 -: 8];
  assign duty_cycle  = act_q.duty;
  assign busy        = (state_q != IDLE);
  assign out_en      = busy;
  assign period_tick = tick_q;
  assign done        = done_q;
  assign cfg_ready   = ready_q;

endmodule

// File: tb/tb_wave_ctrl.sv
// Self-checking bench for wave_ctrl: expected tick events are queued as
// stimulus is planned and popped as the DUT reports period ticks.
module tb_wave_ctrl;

  logic        clk, rst_n;
  logic        cfg_valid, cfg_ready;
  logic [15:0] cfg_inc;
  logic [7:0]  cfg_duty;
  logic [3:0]  cfg_step;
  logic [7:0]  cfg_cycles;
  logic        start, stop;
  logic [7:0]  phase, duty_cycle;
  logic        out_en, period_tick, done, busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         cyc;
    logic [7:0] duty;
    logic       dn;
    logic       bsy;
  } exp_t;
  exp_t exp_q[$];

  wave_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_inc    (cfg_inc),
    .cfg_duty   (cfg_duty),
    .cfg_step   (cfg_step),
    .cfg_cycles (cfg_cycles),
    .start      (start),
    .stop       (stop),
    .phase      (phase),
    .duty_cycle (duty_cycle),
    .out_en     (out_en),
    .period_tick(period_tick),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] inc, input logic [7:0] d,
                         input logic [3:0] s, input logic [7:0] c);
    cfg_inc = inc; cfg_duty = d; cfg_step = s; cfg_cycles = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    set_cfg(16'h0, 8'h0, 4'h0, 8'h0);
    exp_q.delete();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    tick_clk();
  endtask

  // Offer a config in IDLE and wait (bounded) for it to be taken.
  task automatic send_cfg(input logic [15:0] inc, input logic [7:0] d,
                          input logic [3:0] s, input logic [7:0] c);
    int n = 0;
    set_cfg(inc, d, s, c);
    cfg_valid = 1'b1;
    while (cfg_ready !== 1'b1 && n < 20) begin
      tick_clk();
      n++;
    end
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_cfg: cfg_ready=%b required 1 within 20 cycles", cfg_ready);
    end
    tick_clk();
    cfg_valid = 1'b0;
  endtask

  // Start a run; the edge inside this task is cycle 0 of the run.
  task automatic start_run();
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || out_en !== 1'b1 || phase !== 8'h00 || period_tick !== 1'b0) begin
      bad++;
      $display("FAIL start_run: busy=%b out_en=%b phase=%h tick=%b required 1 1 00 0",
               busy, out_en, phase, period_tick);
    end
  endtask

  // Step cycles k0..k1 of a run; check phase while k < ph_until, drive stop at
  // cycle stop_at, raise cfg_valid at cfg_at, drop it once accepted, and match
  // every tick/done against the expected queue.
  task automatic monitor(input int k0, input int k1, input int ph_inc,
                         input int ph_until, input int stop_at, input int cfg_at);
    exp_t       e;
    logic       took;
    logic [7:0] ph_exp;
    for (int k = k0; k <= k1; k++) begin
      if (k == cfg_at) cfg_valid = 1'b1;
      stop = (k == stop_at);
      took = cfg_valid && cfg_ready;
      tick_clk();
      stop = 1'b0;
      if (took) cfg_valid = 1'b0;
      if (k < ph_until) begin
        ph_exp = 8'(((k * ph_inc) % 65536) >> 8);
        total++;
        if (phase !== ph_exp) begin
          bad++;
          $display("FAIL phase@%0d: got %h want %h", k, phase, ph_exp);
        end
      end
      if (period_tick === 1'b1 || done === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL tick@%0d: unexpected tick=%b done=%b", k, period_tick, done);
        end else begin
          e = exp_q.pop_front();
          if (k != e.cyc || duty_cycle !== e.duty || done !== e.dn || busy !== e.bsy) begin
            bad++;
            $display("FAIL tick@%0d: cyc/duty/done/busy got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                     k, k, duty_cycle, done, busy, e.cyc, e.duty, e.dn, e.bsy);
          end
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected ticks never seen, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    set_cfg(16'h0, 8'h0, 4'h0, 8'h0);
    #12;
    total++;
    if ({phase, duty_cycle, out_en, period_tick, done, busy, cfg_ready} !== 21'h0) begin
      bad++;
      $display("FAIL reset_vals: phase=%h duty=%h en=%b tick=%b done=%b busy=%b rdy=%b want all 0",
               phase, duty_cycle, out_en, period_tick, done, busy, cfg_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge: got %b want 0", cfg_ready);
    end
    tick_clk();
    total++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ready_after_edge: ready=%b busy=%b want 1 0", cfg_ready, busy);
    end
  endtask

  task automatic test_burst();
    do_reset();
    send_cfg(16'h1000, 8'd128, 4'd0, 8'd2);
    start_run();
    exp_q.push_back('{cyc: 16, duty: 8'd128, dn: 1'b0, bsy: 1'b1});
    exp_q.push_back('{cyc: 32, duty: 8'd128, dn: 1'b1, bsy: 1'b0});
    monitor(1, 32, 16'h1000, 32, 0, 0);
    total++;
    if (out_en !== 1'b0 || phase !== 8'h00 || done !== 1'b1) begin
      bad++;
      $display("FAIL burst_end: out_en=%b phase=%h done=%b want 0 00 1", out_en, phase, done);
    end
    monitor(33, 40, 0, 0, 0, 0);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL burst_after: done=%b busy=%b want 0 0", done, busy);
    end
    check_drained("burst");
  endtask

  task automatic test_sweep();
    logic [7:0] d = 8'd200;
    do_reset();
    send_cfg(16'h4000, 8'd200, 4'd15, 8'd0);
    total++;
    if (duty_cycle !== 8'd200) begin
      bad++;
      $display("FAIL sweep_init: duty=%0d want 200", duty_cycle);
    end
    start_run();
    for (int i = 1; i <= 6; i++) begin
      d = (d > 8'd240) ? 8'd255 : d + 8'd15;
      exp_q.push_back('{cyc: 4 * i, duty: d, dn: 1'b0, bsy: 1'b1});
    end
    monitor(1, 26, 16'h4000, 27, 0, 0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL sweep_cont: busy=%b want 1", busy);
    end
    check_drained("sweep");
  endtask

  task automatic test_stop();
    do_reset();
    send_cfg(16'h1000, 8'd50, 4'd0, 8'd0);
    start_run();
    exp_q.push_back('{cyc: 16, duty: 8'd50, dn: 1'b0, bsy: 1'b0});
    monitor(1, 6, 16'h1000, 16, 5, 0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL stopping_busy: busy=%b want 1", busy);
    end
    monitor(7, 20, 16'h1000, 16, 0, 0);
    total++;
    if (busy !== 1'b0 || phase !== 8'h00 || out_en !== 1'b0) begin
      bad++;
      $display("FAIL stop_end: busy=%b phase=%h out_en=%b want 0 00 0", busy, phase, out_en);
    end
    check_drained("stop");
  endtask

  task automatic test_cfg_run();
    do_reset();
    send_cfg(16'h1000, 8'd100, 4'd0, 8'd0);
    start_run();
    set_cfg(16'h2000, 8'd64, 4'd0, 8'd0);
    monitor(1, 3, 16'h1000, 16, 0, 1);
    total++;
    if (cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_drop: cfg_ready=%b want 0", cfg_ready);
    end
    set_cfg(16'h3000, 8'd7, 4'd0, 8'd0);
    exp_q.push_back('{cyc: 16, duty: 8'd64, dn: 1'b0, bsy: 1'b1});
    exp_q.push_back('{cyc: 24, duty: 8'd7,  dn: 1'b0, bsy: 1'b1});
    exp_q.push_back('{cyc: 30, duty: 8'd7,  dn: 1'b0, bsy: 1'b1});
    monitor(4, 15, 16'h1000, 16, 0, 4);
    total++;
    if (cfg_ready !== 1'b0 || cfg_valid !== 1'b1) begin
      bad++;
      $display("FAIL cfg_stall: ready=%b still_offered=%b want 0 1", cfg_ready, cfg_valid);
    end
    monitor(16, 32, 0, 0, 0, 0);
    check_drained("cfg_run");
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_cfg(16'h1000, 8'd90, 4'd0, 8'd0);
    start = 1'b1; stop = 1'b1;
    tick_clk();
    start = 1'b0; stop = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_stop: busy=%b want 0", busy);
    end
    start_run();
    set_cfg(16'h2000, 8'd33, 4'd0, 8'd0);
    exp_q.push_back('{cyc: 16, duty: 8'd90, dn: 1'b0, bsy: 1'b1});
    exp_q.push_back('{cyc: 32, duty: 8'd33, dn: 1'b0, bsy: 1'b1});
    exp_q.push_back('{cyc: 40, duty: 8'd33, dn: 1'b0, bsy: 1'b1});
    monitor(1, 42, 16'h1000, 16, 0, 16);
    check_drained("wrap_cfg");
  endtask

  task automatic test_reset_midrun();
    do_reset();
    send_cfg(16'h1000, 8'd77, 4'd3, 8'd0);
    start_run();
    set_cfg(16'h2000, 8'd9, 4'd0, 8'd0);
    monitor(1, 5, 16'h1000, 6, 0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({phase, duty_cycle, out_en, period_tick, done, busy, cfg_ready} !== 21'h0) begin
      bad++;
      $display("FAIL async_reset: phase=%h duty=%h en=%b tick=%b done=%b busy=%b rdy=%b want all 0",
               phase, duty_cycle, out_en, period_tick, done, busy, cfg_ready);
    end
    cfg_valid = 1'b0;
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    tick_clk();
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    tick_clk();
    total++;
    if (busy !== 1'b0 || duty_cycle !== 8'd0 || period_tick !== 1'b0) begin
      bad++;
      $display("FAIL start_inc0: busy=%b duty=%0d tick=%b want 0 0 0", busy, duty_cycle, period_tick);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_sweep();
    test_stop();
    test_cfg_run();
    test_back_to_back();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_ctrl.md
# wave_ctrl

Sequencing controller for the rectangular-wave datapath. It owns a phase accumulator and drives the `phase` and `duty_cycle` inputs of the rectangle generator. It accepts configuration through a valid/ready handshake, runs continuous or counted bursts of periods, and optionally sweeps the duty cycle once per period. It sits between the control/register interface and the waveform generators.

## Interface
- `ACC_W`, 16: phase accumulator width; output phase is the top 8 bits.
- `CNT_W`, 8: burst period counter width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  configuration accepted when `cfg_valid && cfg_ready`.
- `cfg_inc`  in  ACC_W  phase increment per clock.
- `cfg_duty`  in  8  initial duty cycle, 0-255.
- `cfg_step`  in  4  duty increment per period; 0 means no sweep.
- `cfg_cycles`  in  CNT_W  burst length in periods; 0 means continuous.
- `start`  in  1  level-sampled; begins a run.
- `stop`  in  1  level-sampled; ends a run at the next period boundary.
- `phase`  out  8  registered; drives the generator phase.
- `duty_cycle`  out  8  registered; drives the generator duty.
- `out_en`  out  1  high while the generator output is valid.
- `period_tick`  out  1  one-cycle pulse on each accumulator wrap.
- `done`  out  1  one-cycle pulse when a counted burst completes.
- `busy`  out  1  state is not IDLE.

## Operation
- Two configuration sets are held: active (`inc`, `duty`, `step`, `cycles`) and pending, with a `pend_full` flag.
- IDLE:
  - `cfg_ready=1`; an accepted config writes the active set directly.
  - `start && !stop && inc!=0` moves to RUN.
  - `start` with `inc==0` is ignored.
  - `start` and `stop` in the same cycle: stop wins, stay IDLE.
- RUN:
  - `acc <= acc + inc` each cycle; `phase = acc[ACC_W-1 -: 8]`.
  - Wrap is the carry out of `acc + inc`. The carry is dropped, so `acc` wraps modulo 2^ACC_W.
  - On each wrap:
    - `period_tick` pulses and `cnt` increments.
    - `duty <= min(duty + step, 255)`, computed 9-bit then saturated.
    - If `pend_full`: pending copies to active (`duty` takes `cfg_duty`, not the swept value) and `pend_full` clears.
- Config during RUN:
  - `cfg_ready = !pend_full`; an accepted config loads the pending set.
  - A config accepted in the same cycle as a wrap is applied at the following wrap, not the current one.
- Burst end: if `cycles!=0` and the wrap makes `cnt==cycles`, go to IDLE and pulse `done`.
- STOPPING: entered from RUN when `stop` is sampled. Accumulation continues; at the next wrap go to IDLE, with no `done` pulse.
- Leaving RUN/STOPPING: `acc`, `cnt` and `phase` clear to 0; `out_en` falls.
- `busy = (state != IDLE)`.
- States are IDLE, RUN, STOPPING. STOPPING ignores `stop`, and `start` has no effect outside IDLE.
- A burst-complete wrap in STOPPING exits without `done`.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - `phase=0`, `duty_cycle=0`, `out_en=0`, `period_tick=0`, `done=0`, `busy=0`, `cfg_ready=0`.
  - State IDLE; active and pending sets zeroed; `pend_full=0`.
- `cfg_ready` rises on the first clock edge after `rst_n` deasserts.
- Start latency: `start` sampled at edge N gives state RUN, `out_en=1`, `phase=0` after N. `phase` first advances after N+1.
- Period: exactly `2^ACC_W / inc` cycles when `inc` divides 2^ACC_W; otherwise the period is fractional and jitters by 1 cycle.
- `period_tick`, `duty_cycle` and `done` update on the same edge that registers the wrapped `acc`.
- At burst end, `done=1`, `out_en=0`, `phase=0` in the same cycle; `done` clears the next cycle.
- Reset mid-run aborts immediately. No `done` pulse; the pending config is lost.

## Structure
- `wave_pkg` holds:
  - `state_t` enum {IDLE, RUN, STOPPING};
  - the `cfg_t` packed struct (inc, duty, step, cycles);
  - `DUTY_MAX = 8'd255`.
- One sub-module, `phase_acc`: the ACC_W accumulator with `clr`, `en` and `inc` inputs, and `acc` and `wrap` outputs. The FSM, config registers and duty sweep live in `wave_ctrl`.

## Test plan
- Counted burst, no sweep: cfg inc=0x1000, duty=128, step=0, cycles=2, then start.
  - `phase` steps 0x00,0x10,…,0xF0.
  - `period_tick` every 16 cycles.
  - `done` pulses 32 cycles after RUN entry; `out_en` falls in the same cycle.
- Saturating sweep, continuous: inc=0x4000, duty=200, step=15, cycles=0.
  - `duty_cycle` goes 200, 215, 230, 245, 255, 255 at successive ticks; never finishes.
- Stop mid-period: inc=0x1000, assert `stop` at cycle 5 of a period.
  - Run ends at the wrap 11 cycles later, with no `done` and `phase=0`.
- Config during RUN, applied at the wrap: in RUN with inc=0x1000, offer inc=0x2000, duty=64.
  - `cfg_ready` drops after acceptance.
  - At the next wrap, `duty_cycle=64` and the period becomes 8 cycles.
  - A second config while `pend_full=1` is stalled.
- Simultaneous events: `start` with `stop` in IDLE stays IDLE. A config accepted on a wrap cycle applies only at the next wrap.
- Reset mid-run: drop `rst_n` during RUN. All outputs go to 0 asynchronously; after release, state is IDLE and `start` without a new config is ignored (`inc=0`).
